// File: rtl/capture_if.sv
// Sample-RAM and readout bus of the capture sequencer.
// master = capture_ctrl side, slave = the sample source, the RAM and the readout consumer.
interface capture_if #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8
);
  logic                 sample_valid_i;
  logic [DATA_SIZE-1:0] sample_data_i;
  logic                 w_en_o;
  logic [ADDR_SIZE-1:0] w_addr_o;
  logic [DATA_SIZE-1:0] w_data_o;
  logic [ADDR_SIZE-1:0] r_addr_o;
  logic [DATA_SIZE-1:0] r_data_i;
  logic                 rd_valid_o;
  logic [DATA_SIZE-1:0] rd_data_o;
  logic                 rd_last_o;
  logic                 rd_ready_i;

  // Readout handshake: a beat transfers on a cycle with rd_valid_o & rd_ready_i.
  // While rd_valid_o is high and the beat has not transferred, data/last/address are held stable.
  modport master (
    input  sample_valid_i, sample_data_i, r_data_i, rd_ready_i,
    output w_en_o, w_addr_o, w_data_o, r_addr_o, rd_valid_o, rd_data_o, rd_last_o
  );

  modport slave (
    output sample_valid_i, sample_data_i, r_data_i, rd_ready_i,
    input  w_en_o, w_addr_o, w_data_o, r_addr_o, rd_valid_o, rd_data_o, rd_last_o
  );
endinterface

// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer: circular pre-trigger buffering into the sample RAM,
// level-crossing or forced trigger, post-trigger collection, then one record streamed out.
module capture_ctrl #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  capture_if.master            bus,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 force_i,
  input  logic [ADDR_SIZE-1:0] pretrig_i,
  input  logic [DATA_SIZE-1:0] trig_level_i,
  input  logic                 trig_rising_i,
  output logic                 busy_o,
  output logic                 triggered_o,
  output logic [2:0]           state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FILL    = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] POST    = 3'd3;
  localparam logic [2:0] READOUT = 3'd4;

  localparam logic [ADDR_SIZE-1:0] A_ONE   = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] A_MAX   = {ADDR_SIZE{1'b1}};
  localparam logic [ADDR_SIZE:0]   R_ONE   = (ADDR_SIZE + 1)'(1);
  localparam logic [ADDR_SIZE:0]   REC_LEN = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [2:0]           state;
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr, trig_addr;
  logic [ADDR_SIZE-1:0] pre_cnt, post_cnt;
  logic [ADDR_SIZE:0]   remaining;
  logic [ADDR_SIZE-1:0] cfg_p;
  logic [DATA_SIZE-1:0] cfg_level;
  logic                 cfg_rising;
  logic [DATA_SIZE-1:0] prev_sample;
  logic                 prev_ok;
  logic                 force_pend;
  logic                 triggered;

  logic                 wr_fire;
  logic                 rd_valid;
  logic                 xfer;
  logic                 crossing;
  logic                 trig_hit;
  logic [ADDR_SIZE-1:0] post_init;
  logic [ADDR_SIZE-1:0] pre_next;

  assign wr_fire = bus.sample_valid_i & ~abort_i &
                   ((state == FILL) | (state == ARMED) | (state == POST));
  assign rd_valid = (state == READOUT) & ~abort_i;
  assign xfer     = rd_valid & bus.rd_ready_i;

  assign bus.w_en_o     = wr_fire;
  assign bus.w_addr_o   = wr_ptr;
  assign bus.w_data_o   = wr_fire ? bus.sample_data_i : '0;
  assign bus.r_addr_o   = rd_ptr;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_data_o  = rd_valid ? bus.r_data_i : '0;
  assign bus.rd_last_o  = rd_valid & (remaining == R_ONE);

  assign busy_o      = (state != IDLE);
  assign triggered_o = triggered;
  assign state_o     = state;

  // Crossing compares against the previous written sample, so it is meaningful only once prev_ok is set.
  assign crossing = cfg_rising ?
                    ((prev_sample < cfg_level) && (bus.sample_data_i >= cfg_level)) :
                    ((prev_sample > cfg_level) && (bus.sample_data_i <= cfg_level));
  assign trig_hit  = (state == ARMED) & wr_fire & (force_i | force_pend | (prev_ok & crossing));
  assign post_init = A_MAX - cfg_p;
  assign pre_next  = pre_cnt + A_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trig_addr   <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      remaining   <= '0;
      cfg_p       <= '0;
      cfg_level   <= '0;
      cfg_rising  <= 1'b0;
      prev_sample <= '0;
      prev_ok     <= 1'b0;
      force_pend  <= 1'b0;
      triggered   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr      <= wr_ptr + A_ONE;
        prev_sample <= bus.sample_data_i;
        prev_ok     <= 1'b1;
      end

      if (abort_i) begin
        state      <= IDLE;
        triggered  <= 1'b0;
        force_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_i) begin
              cfg_p      <= pretrig_i;
              cfg_level  <= trig_level_i;
              cfg_rising <= trig_rising_i;
              triggered  <= 1'b0;
              pre_cnt    <= '0;
              prev_ok    <= 1'b0;
              force_pend <= 1'b0;
              state      <= (pretrig_i != '0) ? FILL : ARMED;
            end
          end
          FILL: begin
            if (wr_fire) begin
              pre_cnt <= pre_next;
              if (pre_next == cfg_p) state <= ARMED;
            end
          end
          ARMED: begin
            if (trig_hit) begin
              trig_addr  <= wr_ptr;
              triggered  <= 1'b1;
              force_pend <= 1'b0;
              post_cnt   <= post_init;
              if (post_init == '0) begin
                // With P = N-1 the trigger sample closes the record: start readout right away.
                rd_ptr    <= wr_ptr - cfg_p;
                remaining <= REC_LEN;
                state     <= READOUT;
              end else begin
                state <= POST;
              end
            end else if (force_i) begin
              force_pend <= 1'b1;
            end
          end
          POST: begin
            if (wr_fire) begin
              post_cnt <= post_cnt - A_ONE;
              if (post_cnt == A_ONE) begin
                rd_ptr    <= trig_addr - cfg_p;
                remaining <= REC_LEN;
                state     <= READOUT;
              end
            end
          end
          READOUT: begin
            if (xfer) begin
              rd_ptr    <= rd_ptr + A_ONE;
              remaining <= remaining - R_ONE;
              if (remaining == R_ONE) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl with a behavioural sample RAM, a trigger-condition vector table
// and full-record scenarios checked through an expected-sample queue.
module tb_capture_ctrl;

  logic        clk;
  logic        rst;
  logic        arm, abort_s, frc, rising;
  logic [7:0]  pretrig;
  logic [11:0] level;
  logic        busy, triggered;
  logic [2:0]  state;

  capture_if #(.DATA_SIZE(12), .ADDR_SIZE(8)) bus ();

  capture_ctrl #(.DATA_SIZE(12), .ADDR_SIZE(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus.master),
    .arm_i         (arm),
    .abort_i       (abort_s),
    .force_i       (frc),
    .pretrig_i     (pretrig),
    .trig_level_i  (level),
    .trig_rising_i (rising),
    .busy_o        (busy),
    .triggered_o   (triggered),
    .state_o       (state)
  );

  // Sample RAM: synchronous write, asynchronous read.
  logic [11:0] mem [0:255];
  always @(posedge clk) if (bus.w_en_o) mem[bus.w_addr_o] <= bus.w_data_o;
  assign bus.r_data_i = mem[bus.r_addr_o];

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd2, S_POST = 3'd3, S_READOUT = 3'd4;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] hist[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [11:0] d, input logic f);
    @(negedge clk);
    bus.sample_valid_i = 1'b1;
    bus.sample_data_i  = d;
    frc = f;
    @(posedge clk);
  endtask

  task automatic arm_cfg(input logic [7:0] p, input logic [11:0] lvl, input logic r);
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    frc = 1'b0;
    arm = 1'b1; pretrig = p; level = lvl; rising = r;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    frc = 1'b0;
    abort_s = 1'b1;
    @(posedge clk);
    #1 abort_s = 1'b0;
    check("abort_idle", state, S_IDLE);
  endtask

  // Drain one record; abort_at/arm_at are transfer indices (-1 = never).
  task automatic read_record(input int rd_mode, input int abort_at, input int arm_at);
    int xfers = 0;
    bit stalled = 0;
    bit done = 0;
    logic [11:0] ld, e;
    logic [7:0]  la;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      bus.rd_ready_i     = (rd_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.sample_valid_i = 1'($urandom_range(0, 1));
      bus.sample_data_i  = 12'($urandom_range(0, 4095));
      frc     = 1'b0;
      abort_s = (xfers == abort_at);
      arm     = (xfers == arm_at);
      #1;
      if (abort_s) begin
        check("abort_rd_valid", bus.rd_valid_o, 1'b0);
        check("abort_rd_w_en", bus.w_en_o, 1'b0);
        @(posedge clk);
        #1 abort_s = 1'b0;
        check("abort_rd_state", state, S_IDLE);
        check("abort_rd_trig", triggered, 1'b0);
        exp_q.delete();
        done = 1;
      end else begin
        check("rd_valid", bus.rd_valid_o, 1'b1);
        if (bus.sample_valid_i) check("readout_w_en", bus.w_en_o, 1'b0);
        if (stalled) begin
          check("stall_data", bus.rd_data_o, ld);
          check("stall_addr", bus.r_addr_o, la);
        end
        if (bus.rd_ready_i) begin
          if (exp_q.size() == 0) begin
            check("extra_transfer", 1'b1, 1'b0);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            check("rd_data", bus.rd_data_o, e);
            check("rd_last", bus.rd_last_o, exp_q.size() == 0);
            xfers++;
            if (exp_q.size() == 0) done = 1;
          end
        end
        stalled = !bus.rd_ready_i;
        ld = bus.rd_data_o;
        la = bus.r_addr_o;
        @(posedge clk);
      end
    end
    @(negedge clk);
    bus.rd_ready_i = 1'b0; bus.sample_valid_i = 1'b0; arm = 1'b0; abort_s = 1'b0;
    #1;
    if (!done) check("readout_timeout", 1'b1, 1'b0);
    check("post_read_state", state, S_IDLE);
    check("exp_q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Rising ramp through 0x800 with P=0; abort_post>0 aborts after that many post samples.
  task automatic ramp_capture(input int start, input int abort_post, input int rd_mode,
                              input int rd_abort);
    arm_cfg(8'd0, 12'h800, 1'b1);
    for (int v = start; v < 'h800; v++) send(12'(v), 1'b0);
    send(12'h800, 1'b0);
    exp_q.push_back(12'h800);
    #1;
    check("ramp_trig", triggered, 1'b1);
    check("ramp_post_state", state, S_POST);
    for (int k = 1; k < 256; k++) begin
      if (k == abort_post) begin
        @(negedge clk);
        bus.sample_data_i = 12'h5A5;
        abort_s = 1'b1;
        #1 check("abort_post_w_en", bus.w_en_o, 1'b0);
        @(posedge clk);
        #1 abort_s = 1'b0;
        bus.sample_valid_i = 1'b0;
        check("abort_post_state", state, S_IDLE);
        check("abort_post_trig", triggered, 1'b0);
        check("abort_post_busy", busy, 1'b0);
        exp_q.delete();
        return;
      end
      send(12'(12'h800 + k), 1'b0);
      exp_q.push_back(12'(12'h800 + k));
    end
    #1 check("ramp_readout_state", state, S_READOUT);
    read_record(rd_mode, rd_abort, -1);
  endtask

  typedef struct {
    logic        rising;
    logic [11:0] level;
    logic [11:0] prev;
    logic [11:0] cur;
    logic        f;
    logic        exp_trig;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 12'h800, 12'h7FF, 12'h800, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 12'h800, 12'h800, 12'h900, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 12'h800, 12'h7FF, 12'h7FF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 12'h800, 12'h900, 12'h950, 1'b0, 1'b0};  // stale prev must not count after arm
    vecs[4]  = '{1'b0, 12'h400, 12'h401, 12'h400, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 12'h400, 12'h400, 12'h000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 12'h400, 12'h500, 12'h401, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 12'h800, 12'h900, 12'h100, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 12'h000, 12'h000, 12'hFFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 12'hFFF, 12'hFFE, 12'hFFF, 1'b0, 1'b1};

    rst = 1'b1; arm = 0; abort_s = 0; frc = 0; rising = 0; pretrig = '0; level = '0;
    bus.sample_valid_i = 0; bus.sample_data_i = '0; bus.rd_ready_i = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_trig", triggered, 1'b0);
    check("rst_w_en", bus.w_en_o, 1'b0);
    check("rst_rd_valid", bus.rd_valid_o, 1'b0);
    check("rst_w_addr", bus.w_addr_o, 8'd0);
    check("rst_r_addr", bus.r_addr_o, 8'd0);
    @(negedge clk) rst = 1'b0;

    // Trigger-condition table.
    for (int i = 0; i < 11; i++) begin
      do_abort();
      arm_cfg(8'd0, vecs[i].level, vecs[i].rising);
      send(vecs[i].prev, 1'b0);
      send(vecs[i].cur, vecs[i].f);
      @(negedge clk);
      bus.sample_valid_i = 1'b0; frc = 1'b0;
      #1;
      check($sformatf("vec%0d_trig", i), triggered, vecs[i].exp_trig);
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_trig ? S_POST : S_ARMED);
    end
    do_abort();

    // Rising ramp, consumer always ready.
    ramp_capture('h7F0, -1, 0, -1);

    // Falling trigger with P=16 after 300 armed samples; record wraps the RAM.
    arm_cfg(8'd16, 12'h400, 1'b0);
    hist.delete();
    for (int i = 0; i < 16; i++) begin
      send(12'(12'h800 + i), 1'b0);
      hist.push_back(12'(12'h800 + i));
    end
    #1 check("p16_armed", state, S_ARMED);
    for (int i = 0; i < 300; i++) begin
      logic [11:0] v;
      v = 12'($urandom_range('h401, 'hFFF));
      send(v, 1'b0);
      hist.push_back(v);
    end
    for (int v = 'h410; v > 'h400; v--) begin
      send(12'(v), 1'b0);
      hist.push_back(12'(v));
    end
    #1 check("p16_no_early_trig", triggered, 1'b0);
    send(12'h400, 1'b0);
    #1 check("p16_trig", triggered, 1'b1);
    for (int i = 16; i > 0; i--) exp_q.push_back(hist[hist.size() - i]);
    exp_q.push_back(12'h400);
    for (int k = 1; k < 240; k++) begin
      send(12'(12'h400 - k), 1'b0);
      exp_q.push_back(12'(12'h400 - k));
    end
    #1 check("p16_readout", state, S_READOUT);
    read_record(1, -1, 10);

    // P=255: pending force, trigger sample closes the record.
    arm_cfg(8'd255, 12'h000, 1'b1);
    hist.delete();
    for (int i = 0; i < 255; i++) begin
      logic [11:0] v;
      v = 12'($urandom_range(0, 4095));
      send(v, 1'b0);
      hist.push_back(v);
    end
    #1 check("p255_armed", state, S_ARMED);
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    frc = 1'b1;
    @(posedge clk);
    #1;
    check("p255_force_wait_trig", triggered, 1'b0);
    check("p255_force_wait_state", state, S_ARMED);
    send(12'h123, 1'b0);
    #1;
    check("p255_trig", triggered, 1'b1);
    check("p255_readout", state, S_READOUT);
    for (int i = 255; i > 0; i--) exp_q.push_back(hist[hist.size() - i]);
    exp_q.push_back(12'h123);
    read_record(1, -1, -1);

    // Abort mid-POST, abort mid-READOUT, then a clean re-armed capture.
    ramp_capture('h7F8, 100, 0, -1);
    ramp_capture('h7FC, -1, 1, 50);
    ramp_capture('h7F0, -1, 1, -1);

    // Asynchronous reset mid-FILL.
    arm_cfg(8'd100, 12'h800, 1'b1);
    for (int i = 0; i < 50; i++) send(12'(i), 1'b0);
    @(negedge clk);
    bus.sample_data_i = 12'h555;
    #2 rst = 1'b1;
    #1;
    check("arst_state", state, S_IDLE);
    check("arst_busy", busy, 1'b0);
    check("arst_w_en", bus.w_en_o, 1'b0);
    check("arst_w_addr", bus.w_addr_o, 8'd0);
    check("arst_w_data", bus.w_data_o, 12'd0);
    check("arst_r_addr", bus.r_addr_o, 8'd0);
    check("arst_rd_valid", bus.rd_valid_o, 1'b0);
    check("arst_rd_data", bus.rd_data_o, 12'd0);
    check("arst_rd_last", bus.rd_last_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.sample_valid_i = 1'b0;

    // abort wins over arm in IDLE.
    @(negedge clk);
    abort_s = 1'b1; arm = 1'b1; pretrig = 8'd5;
    @(posedge clk);
    #1 abort_s = 1'b0; arm = 1'b0;
    check("abort_arm_state", state, S_IDLE);
    check("abort_arm_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
